regfile_debug_arbiter: RTL and testbench
========================================

// Module: regfile_debug_arbiter
// PURPOSE
//  Shares the register file's write port and read port 2 between the single-cycle MIPS
//  core and a debug/test requester. A debug request halts the core through core_stall,
//  then runs one debug read or write on the register file and returns the result.
//  Sits between the core datapath and the register file; drives the test_value readout.
// PARAMETERS
//  ADDR_W     6   register address width (matches register file A1/A2/A3)
//  NUM_REGS   32  number of implemented registers; dbg_addr >= NUM_REGS is an error
//  MIN_GAP    2   IDLE cycles forced between debug ops so the core runs (0..15)
//  ZERO_RO    1   1: debug write to register 0 is rejected with dbg_err
// PORTS
//  CLK         in   1       clock, rising edge
//  reset       in   1       asynchronous, active-low
//  core_A2     in   ADDR_W  core read-port-2 address
//  core_WE3    in   1       core write enable
//  core_A3     in   ADDR_W  core write address
//  core_WD3    in   32      core write data
//  core_stall  out  1       freezes the core (PC and state); registered
//  rf_A2       out  ADDR_W  to register file A2
//  rf_WE3      out  1       to register file WE3
//  rf_A3       out  ADDR_W  to register file A3
//  rf_WD3      out  32      to register file WD3
//  rf_RD2      in   32      from register file RD2
//  dbg_req     in   1       debug request; held high until dbg_ack
//  dbg_wr      in   1       1 = write, 0 = read
//  dbg_addr    in   ADDR_W  debug register address
//  dbg_wdata   in   32      debug write data
//  dbg_ack     out  1       one-cycle completion pulse
//  dbg_err     out  1       valid with dbg_ack; 1 = op rejected
//  dbg_rdata   out  32      read result; holds until the next read completes
//  test_value  out  16      dbg_rdata[15:0]
// BEHAVIOUR
//  - Reset: state IDLE, gap_cnt=0; core_stall, dbg_ack, dbg_err, dbg_rdata all 0.
//    Reset during an op drops it with no ack and no register write.
//  - FSM states: IDLE, HALT, ACCESS, RESP.
//  - IDLE: rf_* = core_* (combinational pass-through). gap_cnt decrements toward 0.
//    dbg_req is accepted only when gap_cnt==0. On accept, latch wr/addr/wdata.
//    - Invalid addr (>=NUM_REGS), or write to addr 0 with ZERO_RO=1: go to RESP with err=1.
//      core_stall is not raised for this path.
//    - Otherwise go to HALT.
//  - HALT: core_stall=1, rf_WE3 forced 0. Drains the core. Always goes to ACCESS.
//  - ACCESS: core_stall=1.
//    - Write: rf_A3=addr, rf_WD3=wdata, rf_WE3=1.
//    - Read: rf_A2=addr, rf_WE3=0, and dbg_rdata<=rf_RD2 at the end of the cycle.
//    - Always goes to RESP.
//  - RESP: dbg_ack=1 for exactly one cycle, dbg_err per op. rf_WE3=0 (rf_A2/A3/WD3 pass-through).
//    core_stall stays 1 if it was raised. Next state IDLE, gap_cnt<=MIN_GAP.
//  - core_stall is a flop: set on the edge entering HALT, cleared on the edge leaving RESP.
//  - While core_stall=1, core_WE3 never reaches rf_WE3.
//  - Latency: accept edge -> dbg_ack high 3 cycles later (1 cycle later for rejected ops).
//  - Back-to-back: with dbg_req held after ack, the next accept happens MIN_GAP IDLE
//    cycles later. The core runs unstalled in those cycles. MIN_GAP=0 gives 1 IDLE cycle.
//  - dbg_wr/addr/wdata changing after accept has no effect on the op in flight.
//  - Reads of register 0 are always legal.
// TESTING
//  1 Debug write addr 5 = 0xDEADBEEF while core idle -> stall for HALT/ACCESS/RESP,
//    one rf_WE3 pulse in ACCESS, ack 3 cycles after accept, err=0.
//  2 Debug read addr 5 after test 1 -> dbg_rdata=0xDEADBEEF, test_value=0xBEEF, core_WD3 unused.
//  3 Core writes reg 7 every cycle, debug write reg 7=0x1234 -> no core write during stall,
//    reg 7 = 0x1234 at RESP.
//  4 dbg_addr=40 (NUM_REGS=32) -> ack+err 1 cycle after accept, core_stall never asserts.
//    Write addr 0 -> err=1, reg 0 unchanged.
//  5 dbg_req held high for 3 reads, MIN_GAP=2 -> exactly 2 unstalled cycles between
//    consecutive RESP and HALT, 3 acks total.
//  6 reset low during ACCESS of a write -> all outputs 0 at once, no ack; after release FSM is IDLE.

Source files
------------

// File: rtl/regfile_debug_arbiter_if.sv
// Debug request/response bundle between a debug/test requester and the register-file arbiter.
interface regfile_debug_arbiter_if #(
    parameter int ADDR_W = 6
);
    logic              dbg_req;
    logic              dbg_wr;
    logic [ADDR_W-1:0] dbg_addr;
    logic [31:0]       dbg_wdata;
    logic              dbg_ack;
    logic              dbg_err;
    logic [31:0]       dbg_rdata;

    modport master (
        output dbg_req, dbg_wr, dbg_addr, dbg_wdata,
        input  dbg_ack, dbg_err, dbg_rdata
    );

    modport slave (
        input  dbg_req, dbg_wr, dbg_addr, dbg_wdata,
        output dbg_ack, dbg_err, dbg_rdata
    );
endinterface

// File: rtl/regfile_debug_arbiter.sv
// Shares register-file write port and read port 2 between the MIPS core and a debug requester.
//   state  | meaning
//   IDLE   | core owns the register file; debug request may be accepted once the gap expires
//   HALT   | core frozen, its write suppressed while the pipeline drains
//   ACCESS | debug read or write performed on the register file
//   RESP   | one-cycle ack/err to the requester, core still frozen if it was halted
module regfile_debug_arbiter #(
    parameter int ADDR_W   = 6,
    parameter int NUM_REGS = 32,
    parameter int MIN_GAP  = 2,
    parameter int ZERO_RO  = 1
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [ADDR_W-1:0] core_A2,
    input  logic              core_WE3,
    input  logic [ADDR_W-1:0] core_A3,
    input  logic [31:0]       core_WD3,
    output logic              core_stall,
    output logic [ADDR_W-1:0] rf_A2,
    output logic              rf_WE3,
    output logic [ADDR_W-1:0] rf_A3,
    output logic [31:0]       rf_WD3,
    input  logic [31:0]       rf_RD2,
    regfile_debug_arbiter_if.slave dbg,
    output logic [15:0]       test_value
);

    typedef enum logic [1:0] {IDLE, HALT, ACCESS, RESP} state_t;

    localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W+1)'(NUM_REGS);
    // The accept cycle itself counts as one of the forced IDLE cycles.
    localparam logic [3:0]      GAP_LOAD   = (MIN_GAP == 0) ? 4'd0 : 4'(MIN_GAP - 1);

    state_t            state, state_nxt;
    logic [3:0]        gap_cnt;
    logic              op_wr;
    logic              op_err;
    logic [ADDR_W-1:0] op_addr;
    logic [31:0]       op_wdata;
    logic [31:0]       rdata_q;
    logic              accept;
    logic              bad_addr;
    logic              ro_hit;

    assign bad_addr = ({1'b0, dbg.dbg_addr} >= NUM_REGS_L);
    assign ro_hit   = (ZERO_RO != 0) && dbg.dbg_wr && (dbg.dbg_addr == '0);
    assign accept   = (state == IDLE) && (gap_cnt == 4'd0) && dbg.dbg_req;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        rf_A2       = core_A2;
        rf_A3       = core_A3;
        rf_WD3      = core_WD3;
        rf_WE3      = core_WE3 && !core_stall;
        dbg.dbg_ack = 1'b0;
        dbg.dbg_err = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (bad_addr || ro_hit) ? RESP : HALT;
                end
            end
            HALT: begin
                rf_WE3    = 1'b0;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                if (op_wr) begin
                    rf_A3  = op_addr;
                    rf_WD3 = op_wdata;
                    rf_WE3 = 1'b1;
                end else begin
                    rf_A2  = op_addr;
                    rf_WE3 = 1'b0;
                end
                state_nxt = RESP;
            end
            RESP: begin
                rf_WE3      = 1'b0;
                dbg.dbg_ack = 1'b1;
                dbg.dbg_err = op_err;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            gap_cnt    <= 4'd0;
            core_stall <= 1'b0;
            op_wr      <= 1'b0;
            op_err     <= 1'b0;
            op_addr    <= '0;
            op_wdata   <= 32'd0;
            rdata_q    <= 32'd0;
        end else begin
            if (state == RESP) begin
                gap_cnt <= GAP_LOAD;
            end else if ((state == IDLE) && (gap_cnt != 4'd0)) begin
                gap_cnt <= gap_cnt - 4'd1;
            end
            if (accept) begin
                op_wr    <= dbg.dbg_wr;
                op_addr  <= dbg.dbg_addr;
                op_wdata <= dbg.dbg_wdata;
                op_err   <= bad_addr || ro_hit;
            end
            if ((state == IDLE) && (state_nxt == HALT)) begin
                core_stall <= 1'b1;
            end else if (state == RESP) begin
                core_stall <= 1'b0;
            end
            if ((state == ACCESS) && !op_wr) begin
                rdata_q <= rf_RD2;
            end
        end
    end

    assign dbg.dbg_rdata = rdata_q;
    assign test_value    = rdata_q[15:0];

endmodule

// File: tb/tb_regfile_debug_arbiter.sv
// Self-checking bench: register-file model plus a transaction-level expectation of each debug op.
module tb_regfile_debug_arbiter;

    localparam int ADDR_W   = 6;
    localparam int NUM_REGS = 32;
    localparam int MIN_GAP  = 2;
    localparam int ZERO_RO  = 1;
    localparam int GAP_IDLE = (MIN_GAP == 0) ? 1 : MIN_GAP;

    logic              CLK = 1'b0;
    logic              reset = 1'b0;
    logic [ADDR_W-1:0] core_A2 = '0;
    logic              core_WE3 = 1'b0;
    logic [ADDR_W-1:0] core_A3 = '0;
    logic [31:0]       core_WD3 = 32'd0;
    logic              core_stall;
    logic [ADDR_W-1:0] rf_A2;
    logic              rf_WE3;
    logic [ADDR_W-1:0] rf_A3;
    logic [31:0]       rf_WD3;
    logic [31:0]       rf_RD2;
    logic [15:0]       test_value;

    logic [31:0] rf_mem [0:63] = '{default: 32'h0};
    logic [31:0] ref_regs [0:63] = '{default: 32'h0};
    logic [31:0] exp_rdata = 32'd0;
    int n_cmp = 0;
    int n_fail = 0;

    regfile_debug_arbiter_if #(.ADDR_W(ADDR_W)) dbg_if ();

    regfile_debug_arbiter #(
        .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .MIN_GAP(MIN_GAP), .ZERO_RO(ZERO_RO)
    ) dut (
        .CLK(CLK), .reset(reset),
        .core_A2(core_A2), .core_WE3(core_WE3), .core_A3(core_A3), .core_WD3(core_WD3),
        .core_stall(core_stall),
        .rf_A2(rf_A2), .rf_WE3(rf_WE3), .rf_A3(rf_A3), .rf_WD3(rf_WD3), .rf_RD2(rf_RD2),
        .dbg(dbg_if), .test_value(test_value)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (rf_WE3) rf_mem[rf_A3] <= rf_WD3;
    assign rf_RD2 = rf_mem[rf_A2];

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK); #1;
            dbg_if.dbg_req = 1'b0;
            core_WE3 = 1'b0;
        end
    endtask

    // Starts in an IDLE cycle with the gap expired; ends at the negedge of the first IDLE after RESP.
    // core_mode: 0 core quiet, 1 random core writes, 2 core writes core_tgt every cycle.
    task automatic run_op(input logic wr, input logic [5:0] addr, input logic [31:0] wdata,
                          input int core_mode, input logic [5:0] core_tgt);
        bit rej, exp_stall, exp_ack, exp_we;
        int lat, bad;
        logic [31:0] cap;
        rej = (int'(addr) >= NUM_REGS) || (wr && addr == 6'd0 && ZERO_RO != 0);
        lat = rej ? 1 : 3;
        cap = 32'd0;
        dbg_if.dbg_req = 1'b1;
        dbg_if.dbg_wr = wr;
        dbg_if.dbg_addr = addr;
        dbg_if.dbg_wdata = wdata;
        for (int k = 0; k <= lat; k++) begin
            if (k > 0) begin
                @(posedge CLK); #1;
                dbg_if.dbg_wr = 1'($urandom % 2);
                dbg_if.dbg_addr = 6'($urandom_range(0, 63));
                dbg_if.dbg_wdata = $urandom;
            end
            case (core_mode)
                1: begin core_WE3 = 1'($urandom % 2); core_A3 = 6'($urandom_range(1, 31)); end
                2: begin core_WE3 = 1'b1; core_A3 = core_tgt; end
                default: core_WE3 = 1'b0;
            endcase
            core_WD3 = $urandom;
            core_A2 = 6'($urandom_range(0, 63));
            @(negedge CLK);
            exp_stall = !rej && (k >= 1);
            exp_ack = (k == lat);
            if (k == lat) exp_we = 1'b0;
            else if (!rej && k == 2) exp_we = wr;
            else if (exp_stall) exp_we = 1'b0;
            else exp_we = core_WE3;
            n_cmp++;
            if (core_stall !== exp_stall) begin
                n_fail++; $display("FAIL stall k=%0d addr=%0d: got %b expected %b", k, addr, core_stall, exp_stall);
            end
            n_cmp++;
            if (dbg_if.dbg_ack !== exp_ack) begin
                n_fail++; $display("FAIL ack k=%0d addr=%0d: got %b expected %b", k, addr, dbg_if.dbg_ack, exp_ack);
            end
            n_cmp++;
            if (rf_WE3 !== exp_we) begin
                n_fail++; $display("FAIL rf_WE3 k=%0d addr=%0d: got %b expected %b", k, addr, rf_WE3, exp_we);
            end
            if (!rej && k == 2 && wr) begin
                n_cmp++;
                if (rf_A3 !== addr || rf_WD3 !== wdata) begin
                    n_fail++; $display("FAIL wr_port: got %0d/%h expected %0d/%h", rf_A3, rf_WD3, addr, wdata);
                end
            end else if (!rej && k == 2) begin
                n_cmp++;
                if (rf_A2 !== addr) begin
                    n_fail++; $display("FAIL rd_addr: got %0d expected %0d", rf_A2, addr);
                end
                cap = ref_regs[addr];
            end else begin
                n_cmp++;
                if (rf_A2 !== core_A2) begin
                    n_fail++; $display("FAIL a2_pass k=%0d: got %0d expected %0d", k, rf_A2, core_A2);
                end
            end
            if (k == lat) begin
                if (!rej && !wr) exp_rdata = cap;
                n_cmp++;
                if (dbg_if.dbg_err !== rej) begin
                    n_fail++; $display("FAIL err addr=%0d wr=%b: got %b expected %b", addr, wr, dbg_if.dbg_err, rej);
                end
                n_cmp++;
                if (dbg_if.dbg_rdata !== exp_rdata || test_value !== exp_rdata[15:0]) begin
                    n_fail++; $display("FAIL rdata: got %h/%h expected %h", dbg_if.dbg_rdata, test_value, exp_rdata);
                end
                if (!rej && wr) begin
                    n_cmp++;
                    if (rf_mem[addr] !== wdata) begin
                        n_fail++; $display("FAIL reg_at_resp %0d: got %h expected %h", addr, rf_mem[addr], wdata);
                    end
                end
            end
            if (!rej && wr && k == 2) ref_regs[addr] = wdata;
            else if (exp_we) ref_regs[core_A3] = core_WD3;
        end
        @(posedge CLK); #1;
        dbg_if.dbg_req = 1'b0;
        core_WE3 = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (core_stall !== 1'b0 || dbg_if.dbg_ack !== 1'b0) begin
            n_fail++; $display("FAIL after_resp: got stall=%b ack=%b expected 0/0", core_stall, dbg_if.dbg_ack);
        end
        bad = 0;
        for (int i = 0; i < 64; i++) if (rf_mem[i] !== ref_regs[i]) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_fail++; $display("FAIL regfile_contents: got %0d differing regs expected 0", bad);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge CLK);
        #1;
        core_A2 = 6'd17; core_A3 = 6'd3; core_WD3 = 32'hCAFE0001; core_WE3 = 1'b1;
        @(negedge CLK);
        n_cmp++;
        if (core_stall !== 1'b0 || dbg_if.dbg_ack !== 1'b0 || dbg_if.dbg_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b%b%b expected 000", core_stall, dbg_if.dbg_ack, dbg_if.dbg_err);
        end
        n_cmp++;
        if (dbg_if.dbg_rdata !== 32'd0 || test_value !== 16'd0) begin
            n_fail++; $display("FAIL reset_rdata: got %h/%h expected 0", dbg_if.dbg_rdata, test_value);
        end
        n_cmp++;
        if (rf_A2 !== 6'd17 || rf_A3 !== 6'd3 || rf_WD3 !== 32'hCAFE0001 || rf_WE3 !== 1'b1) begin
            n_fail++; $display("FAIL reset_pass: got %0d/%0d/%h/%b expected 17/3/cafe0001/1", rf_A2, rf_A3, rf_WD3, rf_WE3);
        end
        core_WE3 = 1'b0;
        reset = 1'b1;
        idle(3);
    endtask

    task automatic test_write();
        run_op(1'b1, 6'd5, 32'hDEADBEEF, 0, 6'd0);
        n_cmp++;
        if (rf_mem[5] !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL write5: got %h expected deadbeef", rf_mem[5]);
        end
        idle(3);
    endtask

    task automatic test_read();
        run_op(1'b0, 6'd5, $urandom, 0, 6'd0);
        n_cmp++;
        if (dbg_if.dbg_rdata !== 32'hDEADBEEF || test_value !== 16'hBEEF) begin
            n_fail++; $display("FAIL read5: got %h/%h expected deadbeef/beef", dbg_if.dbg_rdata, test_value);
        end
        idle(3);
    endtask

    task automatic test_core_contention();
        run_op(1'b1, 6'd7, 32'h00001234, 2, 6'd7);
        idle(3);
    endtask

    task automatic test_reject();
        run_op(1'b0, 6'd40, $urandom, 1, 6'd0);
        idle(3);
        run_op(1'b1, 6'd0, 32'h5555AAAA, 1, 6'd0);
        n_cmp++;
        if (rf_mem[0] !== 32'd0) begin
            n_fail++; $display("FAIL reg0_ro: got %h expected 0", rf_mem[0]);
        end
        idle(3);
        run_op(1'b0, 6'd0, $urandom, 0, 6'd0);
        idle(3);
    endtask

    task automatic test_back_to_back();
        logic [5:0] addrs [3];
        int n_ack, unst, last_ack;
        bit got;
        addrs[0] = 6'd0;
        addrs[1] = 6'($urandom_range(1, 31));
        addrs[2] = 6'($urandom_range(1, 31));
        core_WE3 = 1'b0;
        dbg_if.dbg_req = 1'b1;
        dbg_if.dbg_wr = 1'b0;
        dbg_if.dbg_addr = addrs[0];
        n_ack = 0; unst = 0; last_ack = 0;
        for (int cyc = 0; cyc < 60 && n_ack < 3; cyc++) begin
            @(negedge CLK);
            got = dbg_if.dbg_ack;
            if (got) begin
                n_cmp++;
                if (dbg_if.dbg_rdata !== ref_regs[addrs[n_ack]] || dbg_if.dbg_err !== 1'b0) begin
                    n_fail++; $display("FAIL b2b_data #%0d: got %h err=%b expected %h err=0", n_ack, dbg_if.dbg_rdata, dbg_if.dbg_err, ref_regs[addrs[n_ack]]);
                end
                if (n_ack == 0) begin
                    n_cmp++;
                    if (cyc != 3) begin
                        n_fail++; $display("FAIL b2b_first_latency: got %0d expected 3", cyc);
                    end
                end else begin
                    n_cmp++;
                    if (unst != GAP_IDLE) begin
                        n_fail++; $display("FAIL b2b_unstalled #%0d: got %0d expected %0d", n_ack, unst, GAP_IDLE);
                    end
                    n_cmp++;
                    if (cyc - last_ack != GAP_IDLE + 3) begin
                        n_fail++; $display("FAIL b2b_spacing #%0d: got %0d expected %0d", n_ack, cyc - last_ack, GAP_IDLE + 3);
                    end
                end
                exp_rdata = ref_regs[addrs[n_ack]];
                n_ack++;
                unst = 0;
                last_ack = cyc;
            end else if (!core_stall && n_ack > 0) begin
                unst++;
            end
            @(posedge CLK); #1;
            if (got) begin
                if (n_ack == 3) dbg_if.dbg_req = 1'b0;
                else dbg_if.dbg_addr = addrs[n_ack];
            end
        end
        dbg_if.dbg_req = 1'b0;
        n_cmp++;
        if (n_ack != 3) begin
            n_fail++; $display("FAIL b2b_ack_count: got %0d expected 3", n_ack);
        end
        idle(3);
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] wd;
        wd = ~ref_regs[9];
        core_WE3 = 1'b0;
        dbg_if.dbg_req = 1'b1;
        dbg_if.dbg_wr = 1'b1;
        dbg_if.dbg_addr = 6'd9;
        dbg_if.dbg_wdata = wd;
        @(posedge CLK); #1;
        @(posedge CLK);
        @(negedge CLK);
        n_cmp++;
        if (rf_WE3 !== 1'b1 || core_stall !== 1'b1) begin
            n_fail++; $display("FAIL rst_access: got we=%b stall=%b expected 1/1", rf_WE3, core_stall);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (core_stall !== 1'b0 || dbg_if.dbg_ack !== 1'b0 || dbg_if.dbg_err !== 1'b0 || rf_WE3 !== 1'b0
            || dbg_if.dbg_rdata !== 32'd0 || test_value !== 16'd0) begin
            n_fail++; $display("FAIL rst_outputs: got stall=%b ack=%b err=%b we=%b rdata=%h expected all 0",
                               core_stall, dbg_if.dbg_ack, dbg_if.dbg_err, rf_WE3, dbg_if.dbg_rdata);
        end
        exp_rdata = 32'd0;
        @(posedge CLK);
        @(negedge CLK);
        reset = 1'b1;
        dbg_if.dbg_req = 1'b0;
        n_cmp++;
        if (rf_mem[9] !== ref_regs[9]) begin
            n_fail++; $display("FAIL rst_no_write: got %h expected %h", rf_mem[9], ref_regs[9]);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            n_cmp++;
            if (dbg_if.dbg_ack !== 1'b0 || core_stall !== 1'b0) begin
                n_fail++; $display("FAIL rst_quiet %0d: got ack=%b stall=%b expected 0/0", i, dbg_if.dbg_ack, core_stall);
            end
        end
        @(posedge CLK); #1;
        run_op(1'b0, 6'd9, $urandom, 0, 6'd0);
        idle(3);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            run_op(1'($urandom % 2), 6'($urandom_range(0, 47)), $urandom, 1, 6'd0);
            idle(3);
        end
    endtask

    initial begin
        dbg_if.dbg_req = 1'b0;
        dbg_if.dbg_wr = 1'b0;
        dbg_if.dbg_addr = '0;
        dbg_if.dbg_wdata = 32'd0;
        test_reset();
        test_write();
        test_read();
        test_core_contention();
        test_reject();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 expected earlier end");
        $fatal(1, "watchdog expired");
    end

endmodule
